// File: rtl/bist_user_exec.sv
// -----------------------------------------------------------------------------
// bist_user_exec
//
// Purpose
//   Executes one user test vector {state[3:0], x[1023:0], y[1023:0]} against
//   an external DUT. A START pulse first loads the DUT state. The block then
//   streams x to the DUT as 128 byte beats and compares each DUT reply beat
//   against the matching y byte. At the end it packs a 32-bit result word into
//   a serial shift register that is read out on TDO.
//
// Configuration macro
//   BIST_ERR_LOG_EN : when defined, the block records the index and data of
//                     the first mismatching reply in RESULT[15:0]. When it is
//                     undefined, RESULT[15:0] reads 0 and no logging flops
//                     are built.
//
// Parameters
//   CHUNK_W     : DUT beat width. The design assumes 8, which gives 128 beats.
//   TIMEOUT_CYC : idle cycles without a DUT reply before the run aborts.
//                 The limit is 255 because the idle counter is 8 bits wide.
//
// Ports
//   i_tck          : clock; all logic is on the rising edge
//   i_trst_n       : asynchronous active-low reset
//   i_start        : 1-cycle start pulse; honoured only in IDLE or DONE
//   i_user_test    : test vector; must stay stable while the run is busy
//   o_dut_load     : 1-cycle strobe; the DUT takes o_dut_state
//   o_dut_state    : state field of the test vector
//   o_dut_x        : current stimulus beat
//   o_dut_x_valid  : stimulus valid
//   i_dut_x_ready  : DUT accepts the beat when valid and ready are both high
//   i_dut_y        : DUT reply beat
//   i_dut_y_valid  : reply valid; the DUT cannot be back-pressured
//   i_dut_state_o  : DUT state, captured into the result on DONE entry
//   o_busy         : high from the cycle after START until DONE
//   i_tdi          : serial data in
//   i_shift        : shift enable, qualified by i_enable
//   i_enable       : this register is selected by the TAP
//   o_tdo          : registered serial data out
//
// RESULT[31:0] = {DONE, PASS, TIMEOUT, 0, FINAL_STATE[3:0], ERR_CNT[7:0],
//                 FAIL_IDX[7:0], FAIL_GOT[7:0]}
// -----------------------------------------------------------------------------
module bist_user_exec #(
   parameter int CHUNK_W     = 8,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic               i_tck,
   input  logic               i_trst_n,
   input  logic               i_start,
   input  logic [2051:0]      i_user_test,
   output logic               o_dut_load,
   output logic [3:0]         o_dut_state,
   output logic [CHUNK_W-1:0] o_dut_x,
   output logic               o_dut_x_valid,
   input  logic               i_dut_x_ready,
   input  logic [CHUNK_W-1:0] i_dut_y,
   input  logic               i_dut_y_valid,
   input  logic [3:0]         i_dut_state_o,
   output logic               o_busy,
   input  logic               i_tdi,
   input  logic               i_shift,
   input  logic               i_enable,
   output logic               o_tdo
);

   localparam int          NBEATS     = 1024 / CHUNK_W;
   localparam logic [7:0]  LP_TIMEOUT = 8'(TIMEOUT_CYC);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DRIVE,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_next;

   logic [6:0]        r_tx_k;      // index of the next x beat to send
   logic [7:0]        r_rx_k;      // number of replies compared; bit 7 = all received
   logic [7:0]        r_idle;      // cycles since the last reply or START
   logic [7:0]        r_err_cnt;
   logic              r_timeout;
   logic [31:0]       r_sr;
   logic              r_tdo;

   logic              w_start_ok;
   logic              w_x_hs;
   logic              w_rx_act;
   logic              w_mismatch;
   logic              w_to;
   logic              w_done_entry;
   logic              w_timeout_next;
   logic              w_pass;
   logic [7:0]        w_fail_idx;
   logic [7:0]        w_fail_got;
   logic [31:0]       w_result;

   // Split the vector into per-beat x and y lanes.
   logic [CHUNK_W-1:0] w_x_beat [NBEATS];
   logic [CHUNK_W-1:0] w_y_beat [NBEATS];

   for (genvar gi = 0; gi < NBEATS; gi++) begin : g_beats
      assign w_x_beat[gi] = i_user_test[1024 + gi*CHUNK_W +: CHUNK_W];
      assign w_y_beat[gi] = i_user_test[gi*CHUNK_W +: CHUNK_W];
   end

   assign o_dut_state = i_user_test[2051:2048];
   assign o_tdo       = r_tdo;

   assign w_start_ok  = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_x_hs      = o_dut_x_valid && i_dut_x_ready;

   // Replies count only after the DUT has been loaded and only until 128 have arrived.
   assign w_rx_act    = i_dut_y_valid && !r_rx_k[7] &&
                        ((r_state == ST_DRIVE) || (r_state == ST_DRAIN));
   assign w_mismatch  = (i_dut_y != w_y_beat[r_rx_k[6:0]]);

   // A reply in the abort cycle would still change ERR_CNT. Holding off the
   // timeout for that cycle keeps the captured result consistent.
   assign w_to        = ((r_state == ST_DRIVE) || (r_state == ST_DRAIN)) &&
                        !r_rx_k[7] && !i_dut_y_valid && (r_idle == LP_TIMEOUT);

   assign w_done_entry   = (r_state != ST_DONE) && (w_state_next == ST_DONE);
   assign w_timeout_next = r_timeout || w_to;
   assign w_pass         = (r_err_cnt == 8'd0) && !w_timeout_next;
   assign w_result       = {1'b1, w_pass, w_timeout_next, 1'b0, i_dut_state_o,
                            r_err_cnt, w_fail_idx, w_fail_got};

   // Next state and DUT-facing outputs
   always_comb begin
      w_state_next  = r_state;
      o_dut_load    = 1'b0;
      o_dut_x_valid = 1'b0;
      o_dut_x       = '0;
      o_busy        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) w_state_next = ST_LOAD;
         end
         ST_LOAD: begin
            o_dut_load   = 1'b1;
            o_busy       = 1'b1;
            w_state_next = ST_DRIVE;
         end
         ST_DRIVE: begin
            o_busy        = 1'b1;
            o_dut_x_valid = 1'b1;
            o_dut_x       = w_x_beat[r_tx_k];
            if (w_to)
               w_state_next = ST_DONE;
            else if (w_x_hs && (r_tx_k == 7'd127))
               w_state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            o_busy = 1'b1;
            if (w_to || r_rx_k[7]) w_state_next = ST_DONE;
         end
         ST_DONE: begin
            if (i_start) w_state_next = ST_LOAD;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_tck or negedge i_trst_n) begin
      if (!i_trst_n) r_state <= ST_IDLE;
      else           r_state <= w_state_next;
   end

   always_ff @(posedge i_tck or negedge i_trst_n) begin
      if (!i_trst_n) begin
         r_tx_k    <= '0;
         r_rx_k    <= '0;
         r_idle    <= '0;
         r_err_cnt <= '0;
         r_timeout <= 1'b0;
         r_sr      <= '0;
         r_tdo     <= 1'b0;
      end else begin
         if (w_start_ok) begin
            r_tx_k    <= '0;
            r_rx_k    <= '0;
            r_err_cnt <= '0;
            r_timeout <= 1'b0;
         end else begin
            if (w_x_hs) r_tx_k <= r_tx_k + 7'd1;
            if (w_rx_act) begin
               r_rx_k <= r_rx_k + 8'd1;
               if (w_mismatch && (r_err_cnt != 8'hFF))
                  r_err_cnt <= r_err_cnt + 8'd1;
            end
            if (w_to) r_timeout <= 1'b1;
         end

         // The idle counter saturates so that it cannot wrap past the limit.
         if (i_start || i_dut_y_valid)
            r_idle <= '0;
         else if (r_idle != LP_TIMEOUT)
            r_idle <= r_idle + 8'd1;

         // A result load takes priority over a shift in the same cycle.
         if (w_done_entry) begin
            r_sr <= w_result;
         end else if (i_shift && i_enable) begin
            r_tdo <= r_sr[0];
            r_sr  <= {i_tdi, r_sr[31:1]};
         end
      end
   end

`ifdef BIST_ERR_LOG_EN
   logic [7:0] r_fail_idx;
   logic [7:0] r_fail_got;

   // An ERR_CNT of zero means this mismatch is the first one of the run.
   always_ff @(posedge i_tck or negedge i_trst_n) begin
      if (!i_trst_n) begin
         r_fail_idx <= '0;
         r_fail_got <= '0;
      end else if (w_start_ok) begin
         r_fail_idx <= '0;
         r_fail_got <= '0;
      end else if (w_rx_act && w_mismatch && (r_err_cnt == 8'd0)) begin
         r_fail_idx <= {1'b0, r_rx_k[6:0]};
         r_fail_got <= i_dut_y;
      end
   end

   assign w_fail_idx = r_fail_idx;
   assign w_fail_got = r_fail_got;
`else
   assign w_fail_idx = 8'd0;
   assign w_fail_got = 8'd0;
`endif

endmodule

// File: tb/tb_bist_user_exec.sv
// -----------------------------------------------------------------------------
// Testbench for bist_user_exec.
// The stimulus pushes the expected x beats and the expected result words into
// queues. Monitors compare what the DUT presents on the x channel and on TDO.
// A behavioural identity DUT echoes each accepted x beat one cycle later.
// -----------------------------------------------------------------------------
module tb_bist_user_exec;

   logic          tck = 1'b0;
   logic          trst_n = 1'b0;
   logic          start = 1'b0;
   logic [2051:0] user_test = '0;
   logic          ready = 1'b0;
   logic [7:0]    dut_y = '0;
   logic          dut_y_valid = 1'b0;
   logic [3:0]    dut_state_o = '0;
   logic          tdi = 1'b0;
   logic          shift = 1'b0;
   logic          enable = 1'b0;

   logic          dut_load;
   logic [3:0]    dut_state;
   logic [7:0]    dut_x;
   logic          dut_x_valid;
   logic          busy;
   logic          tdo;

   int            checks = 0;
   int            errors = 0;

   logic [7:0]    exp_x [$];
   logic [31:0]   exp_res [$];
   logic [7:0]    reply_q [$];
   int            reply_limit = 1000;
   int            reply_sent = 0;
   int            hs_count = 0;
   int            ready_mode = 0;   // 0: low, 1: high, 2: toggle every cycle
   logic [7:0]    x_pop;
   logic [31:0]   sh_word = '0;
   int            sh_n = 0;

`ifdef BIST_ERR_LOG_EN
   localparam logic [31:0] EXP_MIS = 32'h8A01_0505;
`else
   localparam logic [31:0] EXP_MIS = 32'h8A01_0000;
`endif

   bist_user_exec dut (
      .i_tck         (tck),
      .i_trst_n      (trst_n),
      .i_start       (start),
      .i_user_test   (user_test),
      .o_dut_load    (dut_load),
      .o_dut_state   (dut_state),
      .o_dut_x       (dut_x),
      .o_dut_x_valid (dut_x_valid),
      .i_dut_x_ready (ready),
      .i_dut_y       (dut_y),
      .i_dut_y_valid (dut_y_valid),
      .i_dut_state_o (dut_state_o),
      .o_busy        (busy),
      .i_tdi         (tdi),
      .i_shift       (shift),
      .i_enable      (enable),
      .o_tdo         (tdo)
   );

   initial forever #5 tck = ~tck;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end else begin
         $display("ok   %s: %h", name, got);
      end
   endtask

   task automatic tick();
      @(posedge tck);
      #1;
   endtask

   // Ready generator
   initial forever begin
      @(posedge tck);
      #1;
      case (ready_mode)
         0:       ready = 1'b0;
         1:       ready = 1'b1;
         default: ready = ~ready;
      endcase
   end

   // Identity DUT model: echoes each accepted x beat in the next cycle.
   initial forever begin
      @(posedge tck);
      #1;
      if (reply_q.size() > 0 && trst_n) begin
         dut_y       = reply_q.pop_front();
         dut_y_valid = 1'b1;
      end else begin
         dut_y       = '0;
         dut_y_valid = 1'b0;
      end
      @(negedge tck);
      if (dut_load) dut_state_o = dut_state;
      if (dut_x_valid && ready && reply_sent < reply_limit) begin
         reply_q.push_back(dut_x);
         reply_sent++;
      end
   end

   // X-channel monitor: the presented beat must match the head of the queue,
   // including during stalls.
   initial forever begin
      @(negedge tck);
      if (dut_x_valid) begin
         if (exp_x.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL x_extra: got %h expected none", dut_x);
         end else begin
            chk(ready ? "x_beat" : "x_stall", 32'(dut_x), 32'(exp_x[0]));
            if (ready) begin
               x_pop = exp_x.pop_front();
               hs_count++;
            end
         end
      end
   end

   // TDO monitor: gathers 32 shifted bits, LSB first, into one result word.
   initial forever begin
      @(posedge tck);
      if (shift && enable) begin
         #1;
         sh_word[sh_n] = tdo;
         sh_n++;
         if (sh_n == 32) begin
            sh_n = 0;
            if (exp_res.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL result_extra: got %h expected none", sh_word);
            end else begin
               chk("result", sh_word, exp_res.pop_front());
            end
         end
      end
   end

   task automatic shift32(input logic [31:0] exp, input logic din);
      exp_res.push_back(exp);
      tdi    = din;
      shift  = 1'b1;
      enable = 1'b1;
      repeat (32) tick();
      shift  = 1'b0;
      enable = 1'b0;
      tick();
      tick();
   endtask

   task automatic start_run(input logic [3:0] st, input bit flip5, input int limit, input int mode);
      for (int k = 0; k < 128; k++) begin
         user_test[1024 + 8*k +: 8] = 8'(k);
         user_test[8*k +: 8]        = 8'(k);
         exp_x.push_back(8'(k));
      end
      if (flip5) user_test[47:40] = 8'hFF;
      user_test[2051:2048] = st;
      reply_limit = limit;
      reply_sent  = 0;
      hs_count    = 0;
      ready_mode  = mode;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_rise", 32'(busy), 32'd1);
      chk("load_strobe", 32'(dut_load), 32'd1);
      tick();
      chk("load_once", 32'(dut_load), 32'd0);
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (busy && n < max) begin
         tick();
         n++;
      end
      chk("busy_fall", 32'(busy), 32'd0);
   endtask

   task automatic wait_hs(input int target, input int max);
      int n = 0;
      while (hs_count < target && n < max) begin
         tick();
         n++;
      end
      chk("hs_reached", 32'(hs_count >= target), 32'd1);
   endtask

   initial begin
      // Reset values
      repeat (3) @(posedge tck);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(dut_x_valid), 32'd0);
      chk("rst_load", 32'(dut_load), 32'd0);
      chk("rst_x", 32'(dut_x), 32'd0);
      chk("rst_tdo", 32'(tdo), 32'd0);
      trst_n = 1'b1;
      tick();

      // The shift register starts empty, so TDI ones do not appear on TDO.
      shift32(32'h0000_0000, 1'b1);

      // Clean pass
      start_run(4'hA, 1'b0, 1000, 1);
      wait_idle(1000);
      chk("x_drained", 32'(exp_x.size()), 32'd0);
      shift32(32'hCA00_0000, 1'b0);

      // y byte 5 flipped
      start_run(4'hA, 1'b1, 1000, 1);
      wait_idle(1000);
      shift32(EXP_MIS, 1'b0);

      // DUT goes silent after 10 replies
      start_run(4'hA, 1'b0, 10, 1);
      wait_idle(2000);
      shift32(32'hAA00_0000, 1'b0);

      // Stalling READY and a START that must be ignored while busy
      start_run(4'h3, 1'b0, 1000, 2);
      wait_hs(30, 500);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_mid_start", 32'(busy), 32'd1);
      wait_idle(2000);
      chk("x_drained_stall", 32'(exp_x.size()), 32'd0);
      shift32(32'hC300_0000, 1'b0);

      // TRST during DRIVE; TDO currently holds 1 from the previous readout.
      start_run(4'hA, 1'b0, 1000, 1);
      wait_hs(60, 500);
      trst_n = 1'b0;
      #1;
      chk("trst_busy", 32'(busy), 32'd0);
      chk("trst_valid", 32'(dut_x_valid), 32'd0);
      chk("trst_tdo", 32'(tdo), 32'd0);
      tick();
      tick();
      exp_x.delete();
      reply_q.delete();
      trst_n = 1'b1;
      tick();
      tick();
      start_run(4'hA, 1'b0, 1000, 1);
      wait_idle(1000);
      shift32(32'hCA00_0000, 1'b0);

      chk("x_queue_empty", 32'(exp_x.size()), 32'd0);
      chk("res_queue_empty", 32'(exp_res.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
